// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: owns the PC, IF/ID and ID/EX registers of the 5-stage pipeline.
// Applies load-use stalls and branch flushes, counts injected bubbles and flags stuck stalls.
module pipe_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CW        = 10,
    parameter int          DW        = 106,
    parameter int          MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_req,
    input  logic          flush_req,
    input  logic [31:0]   pc_next,
    input  logic [31:0]   instr_if,
    input  logic [CW-1:0] ctrl_id,
    input  logic [DW-1:0] data_id,
    output logic [31:0]   pc_q,
    output logic [31:0]   ifid_instr,
    output logic [31:0]   ifid_pc4,
    output logic          ifid_valid,
    output logic [CW-1:0] idex_ctrl,
    output logic [DW-1:0] idex_data,
    output logic          idex_valid,
    output logic          stall_err,
    output logic [15:0]   bubble_cnt
);

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'b111) ? v : v + 3'd1;
    endfunction

    logic       stall_eff;
    logic       bubble;
    logic [2:0] scnt;
    logic [2:0] scnt_next;

    // A flush overrides a simultaneous stall, so only a bare stall freezes the front end.
    assign stall_eff = stall_req & ~flush_req;
    assign bubble    = stall_req | flush_req;

    always_comb begin
        scnt_next = 3'd0;
        if (stall_eff)
            scnt_next = sat_inc(scnt);
    end

    // PC and IF/ID stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (flush_req) begin
            pc_q       <= pc_next;
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (!stall_req) begin
            pc_q       <= pc_next;
            ifid_instr <= instr_if;
            ifid_pc4   <= pc_q + 32'd4;
            ifid_valid <= 1'b1;
        end
    end

    // ID/EX stage: all-zero control marks a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl  <= '0;
            idex_data  <= '0;
            idex_valid <= 1'b0;
        end else if (bubble) begin
            idex_ctrl  <= '0;
            idex_data  <= '0;
            idex_valid <= 1'b0;
        end else begin
            idex_ctrl  <= ctrl_id;
            idex_data  <= data_id;
            idex_valid <= ifid_valid;
        end
    end

    // Bubble counter and stall watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 16'd0;
            scnt       <= 3'd0;
            stall_err  <= 1'b0;
        end else begin
            scnt <= scnt_next;
            if (bubble)
                bubble_cnt <= bubble_cnt + 16'd1;
            if (stall_eff && (int'(scnt_next) >= MAX_STALL))
                stall_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table through a scoreboard queue,
// plus hand-written reset, watchdog and counter-wrap sequences.
module tb_pipe_stall_ctrl;
    localparam int CW = 10;
    localparam int DW = 106;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_req = 1'b0;
    logic          flush_req = 1'b0;
    logic [31:0]   pc_next = '0;
    logic [31:0]   instr_if = '0;
    logic [CW-1:0] ctrl_id = '0;
    logic [DW-1:0] data_id = '0;
    logic [31:0]   pc_q;
    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc4;
    logic          ifid_valid;
    logic [CW-1:0] idex_ctrl;
    logic [DW-1:0] idex_data;
    logic          idex_valid;
    logic          stall_err;
    logic [15:0]   bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .RESET_PC(32'h0000_0000), .CW(CW), .DW(DW), .MAX_STALL(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .pc_next(pc_next), .instr_if(instr_if), .ctrl_id(ctrl_id), .data_id(data_id),
        .pc_q(pc_q), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .idex_ctrl(idex_ctrl), .idex_data(idex_data), .idex_valid(idex_valid),
        .stall_err(stall_err), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic [31:0] data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_ifv;
        logic [9:0]  e_ctrl;
        logic [31:0] e_data;
        logic        e_idv;
        logic [15:0] e_bub;
        logic        e_err;
    } vec_t;

    vec_t vecs[17];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic f);
        stall_req = s;
        flush_req = f;
    endtask

    // Drive one vector at the falling edge, queue its expectation, compare after the next rising edge.
    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        stall_req = v.stall;
        flush_req = v.flush;
        pc_next   = v.pc_next;
        instr_if  = v.instr;
        ctrl_id   = v.ctrl;
        data_id   = DW'(v.data);
        exp_q.push_back(v);
        step(1);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries required 1 (vec %0d)", idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d pc_q", idx),       pc_q,       e.e_pc);
            check($sformatf("v%0d ifid_instr", idx), ifid_instr, e.e_instr);
            check($sformatf("v%0d ifid_pc4", idx),   ifid_pc4,   e.e_pc4);
            check($sformatf("v%0d ifid_valid", idx), ifid_valid, e.e_ifv);
            check($sformatf("v%0d idex_ctrl", idx),  idex_ctrl,  e.e_ctrl);
            check($sformatf("v%0d idex_data", idx),  idex_data,  DW'(e.e_data));
            check($sformatf("v%0d idex_valid", idx), idex_valid, e.e_idv);
            check($sformatf("v%0d bubble_cnt", idx), bubble_cnt, e.e_bub);
            check($sformatf("v%0d stall_err", idx),  stall_err,  e.e_err);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc_q"},       pc_q,       32'h0);
        check({tag, " ifid_instr"}, ifid_instr, 32'h0);
        check({tag, " ifid_valid"}, ifid_valid, 1'b0);
        check({tag, " idex_ctrl"},  idex_ctrl,  '0);
        check({tag, " idex_valid"}, idex_valid, 1'b0);
        check({tag, " stall_err"},  stall_err,  1'b0);
        check({tag, " bubble_cnt"}, bubble_cnt, 16'h0);
    endtask

    initial begin
        //          stall flush pc_next        instr          ctrl    data  | e_pc           e_instr        e_pc4        ifv  e_ctrl  e_data idv  bub    err
        vecs[0]  = '{1'b0, 1'b0, 32'h4,        32'h20080001, 10'h101, 32'hA0, 32'h4,        32'h20080001, 32'h4,  1'b1, 10'h101, 32'hA0, 1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h8,        32'h20090002, 10'h102, 32'hA1, 32'h8,        32'h20090002, 32'h8,  1'b1, 10'h102, 32'hA1, 1'b1, 16'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'hC,        32'h8D2A0000, 10'h103, 32'hA2, 32'h8,        32'h20090002, 32'h8,  1'b1, 10'h000, 32'h0,  1'b0, 16'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'hC,        32'h8D2A0000, 10'h104, 32'hA3, 32'hC,        32'h8D2A0000, 32'hC,  1'b1, 10'h104, 32'hA3, 1'b1, 16'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h10,       32'h012A5820, 10'h105, 32'hA4, 32'h10,       32'h012A5820, 32'h10, 1'b1, 10'h105, 32'hA4, 1'b1, 16'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h40,       32'hAAAA0004, 10'h106, 32'hA5, 32'h40,       32'h0,        32'h0,  1'b0, 10'h000, 32'h0,  1'b0, 16'd2, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h44,       32'h21080004, 10'h107, 32'hA6, 32'h44,       32'h21080004, 32'h44, 1'b1, 10'h107, 32'hA6, 1'b0, 16'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h80,       32'hAAAA0006, 10'h108, 32'hA7, 32'h80,       32'h0,        32'h0,  1'b0, 10'h000, 32'h0,  1'b0, 16'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h84,       32'h11111111, 10'h109, 32'hA8, 32'h84,       32'h11111111, 32'h84, 1'b1, 10'h109, 32'hA8, 1'b0, 16'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h88,       32'h22222222, 10'h10A, 32'hA9, 32'h88,       32'h22222222, 32'h88, 1'b1, 10'h10A, 32'hA9, 1'b1, 16'd3, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'hFF0,      32'h33333333, 10'h3FF, 32'hBB, 32'h88,       32'h22222222, 32'h88, 1'b1, 10'h000, 32'h0,  1'b0, 16'd4, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'hFF0,      32'h33333333, 10'h3FF, 32'hBB, 32'h88,       32'h22222222, 32'h88, 1'b1, 10'h000, 32'h0,  1'b0, 16'd5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'hFF0,      32'h33333333, 10'h3FF, 32'hBB, 32'h88,       32'h22222222, 32'h88, 1'b1, 10'h000, 32'h0,  1'b0, 16'd6, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'hFF0,      32'h33333333, 10'h3FF, 32'hBB, 32'h88,       32'h22222222, 32'h88, 1'b1, 10'h000, 32'h0,  1'b0, 16'd7, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h8C,       32'h44444444, 10'h10B, 32'hAA, 32'h8C,       32'h44444444, 32'h8C, 1'b1, 10'h10B, 32'hAA, 1'b1, 16'd7, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h66666666, 10'h10C, 32'hAB, 32'hFFFFFFFC, 32'h66666666, 32'h90, 1'b1, 10'h10C, 32'hAB, 1'b1, 16'd7, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        32'h55555555, 10'h10D, 32'hAC, 32'h0,        32'h55555555, 32'h0,  1'b1, 10'h10D, 32'hAC, 1'b1, 16'd7, 1'b1};

        // Reset held across clock edges
        step(2);
        check_reset_state("rst_hold");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            run_vec(i);

        // Asynchronous reset mid-cycle, observed before any further edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a stall must not leave a partial stall count behind
        drive(1'b1, 1'b0);
        step(2);
        check("mid_stall bubble_cnt", bubble_cnt, 16'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_stall rst bubble_cnt", bubble_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("post_rst 3 stalls stall_err", stall_err, 1'b0);
        check("post_rst 3 stalls bubble_cnt", bubble_cnt, 16'd3);

        // Flush (with stall) restarts the watchdog count
        drive(1'b1, 1'b1);
        step(1);
        check("flush_stall bubble_cnt", bubble_cnt, 16'd4);
        drive(1'b1, 1'b0);
        step(3);
        check("after_flush 3 stalls stall_err", stall_err, 1'b0);
        step(1);
        check("after_flush 4 stalls stall_err", stall_err, 1'b1);
        check("after_flush bubble_cnt", bubble_cnt, 16'd8);

        // Bubble counter wrap
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0);
        step(65535);
        check("wrap ffff bubble_cnt", bubble_cnt, 16'hFFFF);
        step(1);
        check("wrap zero bubble_cnt", bubble_cnt, 16'h0000);
        check("wrap stall_err", stall_err, 1'b1);
        drive(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
